// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter: the main pipeline normally wins,
// and a starving long-latency unit is forced a grant after STARVE_LIMIT losses.
module wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_ready,
   input  logic        unit_valid,
   input  logic [4:0]  unit_rd,
   input  logic [31:0] unit_data,
   output logic        unit_ready,
   output logic        reg_w_enabled,
   output logic [4:0]  reg_w_addr,
   output logic [31:0] reg_w_data,
   output logic [15:0] stall_cycles
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  wait_q, wait_d;
   logic        wen_q, wen_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] stall_q, stall_d;

   logic starve_force;
   logic grant_pipe;
   logic grant_unit;

   assign starve_force = (wait_q == LIMIT);

   // The two grant terms are mutually exclusive by construction.
   assign pipe_ready = !rst && !starve_force;
   assign unit_ready = !rst && (!pipe_valid || starve_force);
   assign grant_pipe = pipe_valid && pipe_ready;
   assign grant_unit = unit_valid && unit_ready;

   always_comb begin
      wait_d = wait_q;
      if (grant_unit || !unit_valid) begin
         wait_d = 4'd0;
      end else if (wait_q != LIMIT) begin
         wait_d = wait_q + 4'd1;
      end
   end

   // Address and data are zeroed whenever no write is strobed.
   always_comb begin
      wen_d   = 1'b0;
      waddr_d = 5'd0;
      wdata_d = 32'd0;
      if (grant_pipe && (pipe_rd != 5'd0)) begin
         wen_d   = 1'b1;
         waddr_d = pipe_rd;
         wdata_d = pipe_data;
      end else if (grant_unit && (unit_rd != 5'd0)) begin
         wen_d   = 1'b1;
         waddr_d = unit_rd;
         wdata_d = unit_data;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (pipe_valid && !pipe_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q  <= 4'd0;
         wen_q   <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= 32'd0;
         stall_q <= 16'd0;
      end else begin
         wait_q  <= wait_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         stall_q <= stall_d;
      end
   end

   assign reg_w_enabled = wen_q;
   assign reg_w_addr    = waddr_q;
   assign reg_w_data    = wdata_q;
   assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a loss-counting reference model.
module tb_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_ready;
   logic        unit_valid;
   logic [4:0]  unit_rd;
   logic [31:0] unit_data;
   logic        unit_ready;
   logic        reg_w_enabled;
   logic [4:0]  reg_w_addr;
   logic [31:0] reg_w_data;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_losses = 0;
   int          m_stall  = 0;
   logic        m_en     = 1'b0;
   logic [4:0]  m_addr   = '0;
   logic [31:0] m_data   = '0;
   logic        acc_pipe, acc_unit;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
      .unit_valid(unit_valid), .unit_rd(unit_rd), .unit_data(unit_data), .unit_ready(unit_ready),
      .reg_w_enabled(reg_w_enabled), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
      .stall_cycles(stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: apply inputs, check readies, clock, check registered outputs.
   task automatic cycle(input logic r, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic uv, input logic [4:0] urd, input logic [31:0] ud);
      logic starving, exp_pr, exp_ur, win_p, win_u;
      rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
      unit_valid = uv; unit_rd = urd; unit_data = ud;
      #1;
      starving = (m_losses >= LIMIT);
      exp_pr = !r && !starving;
      exp_ur = !r && (!pv || starving);
      chk("pipe_ready", pipe_ready, exp_pr);
      chk("unit_ready", unit_ready, exp_ur);
      win_p = pv && exp_pr;
      win_u = uv && exp_ur;
      @(posedge clk);
      #1;
      if (r) begin
         m_losses = 0; m_stall = 0;
         m_en = 0; m_addr = 0; m_data = 0;
      end else begin
         if (uv && !win_u) m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
         else m_losses = 0;
         if (pv && !exp_pr && m_stall < 65535) m_stall++;
         m_en = 0; m_addr = 0; m_data = 0;
         if (win_p && prd != 0) begin m_en = 1; m_addr = prd; m_data = pd; end
         if (win_u && urd != 0) begin m_en = 1; m_addr = urd; m_data = ud; end
      end
      acc_pipe = win_p;
      acc_unit = win_u;
      chk("reg_w_enabled", reg_w_enabled, m_en);
      chk("reg_w_addr", reg_w_addr, m_addr);
      chk("reg_w_data", reg_w_data, m_data);
      chk("stall_cycles", stall_cycles, m_stall);
   endtask

   initial begin
      logic        p_pend, u_pend;
      logic [4:0]  p_rd, u_rd;
      logic [31:0] p_dat, u_dat;
      logic        r;

      // reset state
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
      chk("rst_wen", reg_w_enabled, 1'b0);

      // pipe only
      cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      chk("pipe_only_acc", acc_pipe, 1'b1);
      chk("pipe_only_data", reg_w_data, 32'hDEADBEEF);
      chk("pipe_only_addr", reg_w_addr, 32'd5);

      // unit only
      cycle(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
      chk("unit_only_acc", acc_unit, 1'b1);
      chk("unit_only_data", reg_w_data, 32'h12345678);

      // rd == 0 accepted, no write
      cycle(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
      chk("rd0_acc", acc_pipe, 1'b1);
      chk("rd0_wen", reg_w_enabled, 1'b0);
      chk("rd0_data", reg_w_data, 32'd0);

      // starvation: pipe wins LIMIT times, then unit is forced
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < LIMIT; i++) begin
         cycle(0, 1, 5'(i + 1), 32'hA000 + i, 1, 5'd9, 32'h99);
         chk("starve_pipe_win", acc_pipe, 1'b1);
      end
      cycle(0, 1, 5'd20, 32'hA0A0, 1, 5'd9, 32'h99);
      chk("forced_unit", acc_unit, 1'b1);
      chk("forced_pipe_blocked", acc_pipe, 1'b0);
      chk("forced_addr", reg_w_addr, 32'd9);
      chk("forced_stall", stall_cycles, 32'd1);
      cycle(0, 1, 5'd20, 32'hA0A0, 1, 5'd10, 32'h77);
      chk("post_force_pipe", acc_pipe, 1'b1);

      // reset mid-starvation restarts the loss count
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
      cycle(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
      chk("midrst_wen", reg_w_enabled, 1'b0);
      chk("midrst_stall", stall_cycles, 32'd0);
      for (int i = 0; i < LIMIT; i++) begin
         cycle(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
         chk("midrst_pipe_win", acc_pipe, 1'b1);
      end
      cycle(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
      chk("midrst_forced", acc_unit, 1'b1);

      // randomized traffic with held pending requests
      p_pend = 0; u_pend = 0; p_rd = 0; u_rd = 0; p_dat = 0; u_dat = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!p_pend && ($urandom % 10) < 7) begin
            p_pend = 1;
            p_rd   = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom);
            p_dat  = $urandom;
         end
         if (!u_pend && ($urandom % 10) < 6) begin
            u_pend = 1;
            u_rd   = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom);
            u_dat  = $urandom;
         end
         r = (($urandom % 64) == 0);
         cycle(r, p_pend, p_pend ? p_rd : 5'd0, p_pend ? p_dat : 32'd0,
               u_pend, u_pend ? u_rd : 5'd0, u_pend ? u_dat : 32'd0);
         if (acc_pipe) p_pend = 0;
         if (acc_unit) u_pend = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
